// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI host.
// Divider defaults and the SD data tokens used by software and benches.
package sd_spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCK_LO = 2'd1,
    SCK_HI = 2'd2
  } state_t;

  localparam int SLOW_DIV_DEF = 62;
  localparam int FAST_DIV_DEF = 3;

  localparam logic [7:0] TOK_START = 8'hFE;
  localparam logic [7:0] TOK_MULTI = 8'hFC;
  localparam logic [7:0] TOK_STOP  = 8'hFD;

endpackage

// File: rtl/sd_spi_host.sv
// SPI mode-0 master for the SD emulator: byte transfers and
// fixed-byte bursts with a slow/fast sck divider.
module sd_spi_host
  import sd_spi_pkg::*;
#(
  parameter int SLOW_DIV = SLOW_DIV_DEF,
  parameter int FAST_DIV = FAST_DIV_DEF,
  parameter int LEN_W    = 10
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [7:0]       tx_data,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             speed,
  input  logic             cs_en,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             busy,
  output logic             ss,
  output logic             sck,
  output logic             mosi,
  input  logic             miso
);

  localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CW      = $clog2(MAX_DIV + 1);
  localparam logic [CW-1:0] SLOW_C = CW'(SLOW_DIV);
  localparam logic [CW-1:0] FAST_C = CW'(FAST_DIV);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    div;
  logic [LEN_W-1:0] len;
  logic [7:0]       data;
  logic [7:0]       shreg;
  logic [7:0]       rxsh;
  logic [7:0]       rx_next;
  logic [2:0]       bit_idx;
  logic             miso_m;
  logic             miso_s;

  assign tx_ready = (state == IDLE) && !reset;
  assign rx_next  = {rxsh[6:0], miso_s};

  // miso comes from the emulator's domain; never reset, just resync
  always_ff @(posedge clk_sys) begin
    miso_m <= miso;
    miso_s <= miso_m;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      ss       <= 1'b1;
      sck      <= 1'b0;
      mosi     <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      busy     <= 1'b0;
      cnt      <= '0;
      div      <= '0;
      len      <= '0;
      data     <= 8'h00;
      shreg    <= 8'h00;
      rxsh     <= 8'h00;
      bit_idx  <= 3'd0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          sck <= 1'b0;
          ss  <= ~cs_en;
          if (tx_valid && tx_ready) begin
            data    <= tx_data;
            shreg   <= tx_data;
            len     <= burst_len;
            div     <= speed ? FAST_C : SLOW_C;
            cnt     <= speed ? FAST_C : SLOW_C;
            mosi    <= tx_data[7];
            bit_idx <= 3'd0;
            busy    <= 1'b1;
            state   <= SCK_LO;
          end
        end
        SCK_LO: begin
          if (cnt == '0) begin
            sck   <= 1'b1;
            cnt   <= div;
            state <= SCK_HI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SCK_HI: begin
          if (cnt == '0) begin
            rxsh <= rx_next;
            sck  <= 1'b0;
            cnt  <= div;
            if (bit_idx != 3'd7) begin
              bit_idx <= bit_idx + 3'd1;
              mosi    <= shreg[6];
              shreg   <= {shreg[6:0], 1'b0};
              state   <= SCK_LO;
            end else begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              // next burst byte starts with no idle gap
              if (len != '0) begin
                len     <= len - 1'b1;
                mosi    <= data[7];
                shreg   <= data;
                bit_idx <= 3'd0;
                state   <= SCK_LO;
              end else begin
                busy  <= 1'b0;
                mosi  <= 1'b1;
                state <= IDLE;
              end
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          sck   <= 1'b0;
          busy  <= 1'b0;
          mosi  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_host.sv
// Randomized bench for sd_spi_host with a behavioural SD slave
// model that logs bytes, sck phase lengths and select level.
module tb_sd_spi_host;
  import sd_spi_pkg::*;

  localparam int LEN_W = 10;
  localparam int SD    = 62;
  localparam int FD    = 3;

  logic             clk_sys = 1'b0;
  logic             reset   = 1'b1;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic [7:0]       tx_data = 8'h00;
  logic [LEN_W-1:0] burst_len = '0;
  logic             speed = 1'b0;
  logic             cs_en = 1'b0;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             busy;
  logic             ss;
  logic             sck;
  logic             mosi;
  logic             miso = 1'b1;

  sd_spi_host #(
    .SLOW_DIV(SD),
    .FAST_DIV(FD),
    .LEN_W(LEN_W)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .burst_len(burst_len),
    .speed(speed),
    .cs_en(cs_en),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .busy(busy),
    .ss(ss),
    .sck(sck),
    .mosi(mosi),
    .miso(miso)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  // slave model and monitor logs (written only by the monitor)
  int         cyc = 0;
  int         rise_n = 0;
  int         fall_n = 0;
  int         rx_n = 0;
  int         mo_n = 0;
  int         busy_cnt = 0;
  logic [7:0] rx_log [0:2047];
  int         rx_t   [0:2047];
  logic [7:0] mo_log [0:2047];
  logic       ss_log [0:8191];
  int         hi_log [0:8191];
  int         lo_log [0:8191];
  int         k = 0;
  bit         have = 0;
  logic [7:0] sb = 8'hFF;
  logic [7:0] mrx = 8'h00;
  logic       sck_d = 1'b0;
  int         hi_run = 0;
  int         lo_run = 0;
  int         src_rd = 0;

  // miso source bytes (written only by the tests)
  logic [7:0] src [0:2047];
  int         src_wr = 0;

  always @(negedge clk_sys) begin
    cyc++;
    if (reset) begin
      k = 0; have = 0; sck_d = 1'b0; mrx = 8'h00;
      hi_run = 0; lo_run = 0;
    end else begin
      if (busy) busy_cnt++;
      if (rx_valid) begin
        rx_log[rx_n] = rx_data; rx_t[rx_n] = cyc; rx_n++;
      end
      if (sck && !sck_d) begin
        ss_log[rise_n] = ss; lo_log[rise_n] = lo_run; rise_n++;
        mrx = {mrx[6:0], mosi}; hi_run = 0;
      end
      if (!sck && sck_d) begin
        hi_log[fall_n] = hi_run; fall_n++; lo_run = 0; k++;
        if (k == 8) begin
          k = 0; have = 0; mo_log[mo_n] = mrx; mo_n++;
        end
      end
      if (sck) hi_run++;
      else if (busy) lo_run++;
      sck_d = sck;
    end
    if (!have && src_rd < src_wr) begin
      sb = src[src_rd]; src_rd++; have = 1;
    end
    miso = have ? sb[3'(7 - k)] : 1'b1;
  end

  task automatic start(input logic [7:0] d, input int len,
                       input logic spd, input logic cs);
    @(negedge clk_sys);
    tx_data = d; burst_len = LEN_W'(len);
    speed = spd; cs_en = cs; tx_valid = 1'b1;
    @(posedge clk_sys);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk_sys); n++;
    end
    ok = (busy === 1'b0);
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    total++;
    if ({ss, sck, mosi, busy, rx_valid, tx_ready} !== 6'b101000) begin
      bad++;
      $display("FAIL rst_outs got=%b want=101000",
               {ss, sck, mosi, busy, rx_valid, tx_ready});
    end
    total++;
    if (rx_data !== 8'h00) begin
      bad++; $display("FAIL rst_rx_data got=%h want=00", rx_data);
    end
    @(negedge clk_sys) reset = 1'b0;
    @(posedge clk_sys); #1;
    total++;
    if (tx_ready !== 1'b1) begin
      bad++; $display("FAIL rst_tx_ready got=%b want=1", tx_ready);
    end
  endtask

  task automatic test_single();
    int rb, mb, r0, f0, b0;
    bit ok;
    src[src_wr] = 8'hA5; src_wr++;
    @(negedge clk_sys) cs_en = 1'b1;
    repeat (2) @(negedge clk_sys);
    total++;
    if (ss !== 1'b0) begin
      bad++; $display("FAIL single_ss_pre got=%b want=0", ss);
    end
    rb = rx_n; mb = mo_n; r0 = rise_n; f0 = fall_n; b0 = busy_cnt;
    start(8'h40, 0, 1'b1, 1'b1);
    wait_idle(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout busy=%b want=0", busy); end
    total++;
    if (rise_n - r0 != 8) begin
      bad++; $display("FAIL single_rises got=%0d want=8", rise_n - r0);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ss_log[r0+i] !== 1'b0 || lo_log[r0+i] != FD + 1 ||
          hi_log[f0+i] != FD + 1) begin
        bad++;
        $display("FAIL single_phase[%0d] ss=%b lo=%0d hi=%0d want 0/%0d/%0d",
                 i, ss_log[r0+i], lo_log[r0+i], hi_log[f0+i], FD + 1, FD + 1);
      end
    end
    total++;
    if (mo_n - mb != 1 || mo_log[mb] !== 8'h40) begin
      bad++; $display("FAIL single_mosi got=%h want=40", mo_log[mb]);
    end
    total++;
    if (rx_n - rb != 1 || rx_log[rb] !== 8'hA5) begin
      bad++;
      $display("FAIL single_rx n=%0d got=%h want 1/a5", rx_n - rb, rx_log[rb]);
    end
    total++;
    if (busy_cnt - b0 != 64) begin
      bad++; $display("FAIL single_busy got=%0d want=64", busy_cnt - b0);
    end
  endtask

  task automatic test_init();
    int rb, mb, r0, f0, hp;
    logic [7:0] exp_q [$];
    bit ok;
    hp = SD + 1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'($urandom));
      src[src_wr] = exp_q[i]; src_wr++;
    end
    @(negedge clk_sys) cs_en = 1'b0;
    repeat (2) @(negedge clk_sys);
    rb = rx_n; mb = mo_n; r0 = rise_n; f0 = fall_n;
    start(8'hFF, 9, 1'b0, 1'b0);
    wait_idle(10 * 16 * hp + 100, ok);
    total++;
    if (!ok || rise_n - r0 != 80) begin
      bad++; $display("FAIL init_rises got=%0d want=80", rise_n - r0);
    end
    for (int i = 0; i < 80; i++) begin
      total++;
      if (ss_log[r0+i] !== 1'b1 || lo_log[r0+i] != hp ||
          hi_log[f0+i] != hp) begin
        bad++;
        $display("FAIL init_phase[%0d] ss=%b lo=%0d hi=%0d want 1/%0d/%0d",
                 i, ss_log[r0+i], lo_log[r0+i], hi_log[f0+i], hp, hp);
      end
    end
    total++;
    if (rx_n - rb != 10 || mo_n - mb != 10) begin
      bad++;
      $display("FAIL init_count rx=%0d mo=%0d want 10", rx_n - rb, mo_n - mb);
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (mo_log[mb+i] !== 8'hFF || rx_log[rb+i] !== exp_q[i]) begin
        bad++;
        $display("FAIL init_byte[%0d] mosi=%h rx=%h want ff/%h",
                 i, mo_log[mb+i], rx_log[rb+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_block();
    int rb, b0;
    logic [7:0] base;
    bit ok;
    base = 8'($urandom);
    for (int i = 0; i < 514; i++) begin
      src[src_wr] = base + 8'(i); src_wr++;
    end
    repeat (2) @(negedge clk_sys);
    rb = rx_n; b0 = busy_cnt;
    start(8'hFF, 513, 1'b1, 1'b1);
    wait_idle(514 * 64 + 100, ok);
    total++;
    if (!ok || rx_n - rb != 514) begin
      bad++; $display("FAIL block_count got=%0d want=514", rx_n - rb);
    end
    total++;
    if (busy_cnt - b0 != 514 * 64) begin
      bad++; $display("FAIL block_busy got=%0d want=%0d", busy_cnt - b0, 514 * 64);
    end
    for (int i = 0; i < 514; i++) begin
      total++;
      if (rx_log[rb+i] !== base + 8'(i) ||
          (i > 0 && rx_t[rb+i] - rx_t[rb+i-1] != 64)) begin
        bad++;
        $display("FAIL block_rx[%0d] got=%h want=%h", i, rx_log[rb+i],
                 base + 8'(i));
      end
    end
  endtask

  task automatic test_cs_drop();
    int rb, r0, n;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      src[src_wr] = 8'($urandom); src_wr++;
    end
    @(negedge clk_sys) cs_en = 1'b1;
    repeat (2) @(negedge clk_sys);
    rb = rx_n; r0 = rise_n;
    start(8'h3C, 3, 1'b1, 1'b1);
    n = 0;
    while (rx_n - rb < 2 && n < 400) begin @(negedge clk_sys); n++; end
    cs_en = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin @(negedge clk_sys); n++; end
    total++;
    if (busy !== 1'b0 || ss !== 1'b0) begin
      bad++; $display("FAIL cs_at_done busy=%b ss=%b want 0/0", busy, ss);
    end
    @(negedge clk_sys);
    total++;
    if (ss !== 1'b1) begin
      bad++; $display("FAIL cs_after got=%b want=1", ss);
    end
    wait_idle(10, ok);
    for (int i = 0; i < 32; i++) begin
      total++;
      if (ss_log[r0+i] !== 1'b0) begin
        bad++; $display("FAIL cs_rise[%0d] ss=%b want=0", i, ss_log[r0+i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int f0, rn, mb, n;
    logic [7:0] m;
    bit ok;
    src[src_wr] = 8'($urandom); src_wr++;
    @(negedge clk_sys) cs_en = 1'b1;
    repeat (2) @(negedge clk_sys);
    f0 = fall_n; rn = rx_n;
    start(8'($urandom), 0, 1'b1, 1'b1);
    n = 0;
    while (fall_n - f0 < 4 && n < 200) begin @(negedge clk_sys); n++; end
    @(negedge clk_sys) reset = 1'b1;
    @(posedge clk_sys); #1;
    total++;
    if ({sck, ss, busy} !== 3'b010) begin
      bad++;
      $display("FAIL mid_rst sck/ss/busy got=%b want=010", {sck, ss, busy});
    end
    @(negedge clk_sys) reset = 1'b0;
    repeat (80) @(negedge clk_sys);
    total++;
    if (rx_n != rn) begin
      bad++; $display("FAIL mid_rx_pulse got=%0d want=0", rx_n - rn);
    end
    m = 8'($urandom);
    src[src_wr] = m; src_wr++;
    repeat (2) @(negedge clk_sys);
    rn = rx_n; mb = mo_n;
    start(8'h55, 0, 1'b1, 1'b1);
    wait_idle(200, ok);
    total++;
    if (!ok || rx_n - rn != 1 || rx_log[rn] !== m || mo_log[mb] !== 8'h55) begin
      bad++;
      $display("FAIL mid_after rx=%h mosi=%h want %h/55",
               rx_log[rn], mo_log[mb], m);
    end
  endtask

  task automatic test_busy_ignore();
    int rb, mb;
    bit ok;
    src[src_wr] = 8'h99; src_wr++;
    repeat (2) @(negedge clk_sys);
    rb = rx_n; mb = mo_n;
    start(8'hC3, 0, 1'b1, 1'b1);
    tx_valid = 1'b1; tx_data = 8'h18;
    repeat (40) @(negedge clk_sys);
    total++;
    if (tx_ready !== 1'b0) begin
      bad++; $display("FAIL ign_ready got=%b want=0", tx_ready);
    end
    tx_valid = 1'b0;
    wait_idle(200, ok);
    repeat (80) @(negedge clk_sys);
    total++;
    if (mo_n - mb != 1 || mo_log[mb] !== 8'hC3 || rx_n - rb != 1) begin
      bad++;
      $display("FAIL ign_bytes n=%0d mosi=%h want 1/c3", mo_n - mb, mo_log[mb]);
    end
  endtask

  task automatic test_random();
    int rb, mb, r0, b0, len;
    logic [7:0] d;
    logic cs;
    logic [7:0] exp_q [$];
    bit ok;
    for (int t = 0; t < 6; t++) begin
      d = 8'($urandom);
      len = int'($urandom_range(0, 3));
      cs = 1'($urandom);
      exp_q.delete();
      for (int i = 0; i <= len; i++) begin
        exp_q.push_back(8'($urandom));
        src[src_wr] = exp_q[i]; src_wr++;
      end
      repeat (2) @(negedge clk_sys);
      rb = rx_n; mb = mo_n; r0 = rise_n; b0 = busy_cnt;
      start(d, len, 1'b1, cs);
      wait_idle((len + 1) * 64 + 100, ok);
      total++;
      if (!ok || busy_cnt - b0 != (len + 1) * 64 ||
          rise_n - r0 != (len + 1) * 8) begin
        bad++;
        $display("FAIL rnd%0d_timing busy=%0d rises=%0d want %0d/%0d", t,
                 busy_cnt - b0, rise_n - r0, (len + 1) * 64, (len + 1) * 8);
      end
      for (int i = 0; i <= len; i++) begin
        total++;
        if (mo_log[mb+i] !== d || rx_log[rb+i] !== exp_q[i] ||
            ss_log[r0+8*i] !== ~cs) begin
          bad++;
          $display("FAIL rnd%0d_byte%0d mosi=%h rx=%h ss=%b want %h/%h/%b",
                   t, i, mo_log[mb+i], rx_log[rb+i], ss_log[r0+8*i],
                   d, exp_q[i], ~cs);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_init();
    test_block();
    test_cs_drop();
    test_reset_mid();
    test_busy_ignore();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
